ga_generation_ctrl: RTL

//  Parametrised top-level sequencer for the TSP genetic-algorithm datapath.
//  - Steps the stage engines (init, rank, select, breed, mutate, next-gen) through a go/done handshake.
//  - Counts generations and tracks the best route fitness (lowest distance) and the generation it appeared in.
//  - Stops after GENERATIONS generations, or earlier on stagnation when that option is compiled in.

---
 rtl/ga_generation_ctrl_pkg.sv | 28 ++
 rtl/ga_generation_ctrl_if.sv | 26 ++
 rtl/ga_generation_ctrl_best_tracker.sv | 52 +++++
 rtl/ga_generation_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/ga_generation_ctrl_pkg.sv
// Shared types and defaults for the GA generation sequencer.
// Optional stagnation stop is enabled by defining GA_STAGNATION_STOP_EN.
package my_pkg;
  localparam int GA_FIT_W         = 16;
  localparam int GA_GENERATIONS   = 500;
  localparam int GA_POP_SIZE      = 100;
  localparam int GA_ELITE_SIZE    = 20;
  localparam int GA_MUTATION_RATE = 4;
  localparam int GA_STALL_LIMIT   = 50;

  // IDLE sits at the top encoding so the engine stages keep their original codes.
  typedef enum logic [2:0] {
    INITIALIZE  = 3'd0,
    RANK_ROUTES = 3'd1,
    SELECTION   = 3'd2,
    BREED       = 3'd3,
    MUTATE      = 3'd4,
    NEXT_GEN    = 3'd5,
    DONE        = 3'd6,
    IDLE        = 3'd7
  } STATES;

  typedef enum logic {STOP_GENS = 1'b0, STOP_STALL = 1'b1} ga_stop_e;

  function automatic logic is_engine(STATES s);
    return !(s inside {IDLE, DONE});
  endfunction
endpackage

// File: rtl/ga_generation_ctrl_if.sv
// Control/status and stage-engine handshake bundle of the GA sequencer.
interface ga_generation_ctrl_if
  import my_pkg::*;
#(
  parameter int FIT_W = GA_FIT_W,
  parameter int GW    = 9
);
  logic             start, abort;
  STATES            stage;
  logic             stage_go, stage_done, fit_valid;
  logic [FIT_W-1:0] fit_in, best_fit;
  logic [15:0]      pop_size, elite_size, mut_rate;
  logic [GW-1:0]    gen_count, best_gen;
  logic             busy, done, stop_reason;

  modport master (
    input  start, abort, stage_done, fit_valid, fit_in,
    output stage, stage_go, pop_size, elite_size, mut_rate,
           gen_count, best_fit, best_gen, busy, done, stop_reason
  );
  modport slave (
    output start, abort, stage_done, fit_valid, fit_in,
    input  stage, stage_go, pop_size, elite_size, mut_rate,
           gen_count, best_fit, best_gen, busy, done, stop_reason
  );
endinterface

// File: rtl/ga_generation_ctrl_best_tracker.sv
// Best-fitness tracker: keeps the lowest route distance, its generation and,
// with GA_STAGNATION_STOP_EN, the run of consecutive non-improving ranks.
module ga_best_tracker
  import my_pkg::*;
#(
  parameter int FIT_W       = GA_FIT_W,
  parameter int GW          = 9,
  parameter int STALL_LIMIT = GA_STALL_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic             fit_valid,
  input  logic [FIT_W-1:0] fit_in,
  input  logic [GW-1:0]    gen_count,
  output logic [FIT_W-1:0] best_fit,
  output logic [GW-1:0]    best_gen,
  output logic             stall_hit
);
  logic improve;
  assign improve = upd && fit_valid && (fit_in < best_fit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_fit <= '1;
      best_gen <= '0;
    end else if (clr) begin
      best_fit <= '1;
      best_gen <= '0;
    end else if (improve) begin
      best_fit <= fit_in;
      best_gen <= gen_count;
    end
  end

`ifdef GA_STAGNATION_STOP_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [SW-1:0] stall_cnt;

  // Hit is judged on the count this rank would produce, so the stop lands on the limiting rank.
  assign stall_hit = upd && !improve && ((int'(stall_cnt) + 1) >= STALL_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             stall_cnt <= '0;
    else if (clr || improve)                                stall_cnt <= '0;
    else if (upd && (int'(stall_cnt) < STALL_LIMIT))        stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_hit = (STALL_LIMIT < 0);
`endif
endmodule

// File: rtl/ga_generation_ctrl.sv
// GA generation sequencer: steps the stage engines via go/done, counts generations,
// tracks best fitness. Stagnation stop is compiled in with GA_STAGNATION_STOP_EN.
module ga_generation_ctrl
  import my_pkg::*;
#(
  parameter int GENERATIONS   = GA_GENERATIONS,
  parameter int POP_SIZE      = GA_POP_SIZE,
  parameter int ELITE_SIZE    = GA_ELITE_SIZE,
  parameter int MUTATION_RATE = GA_MUTATION_RATE,
  parameter int FIT_W         = GA_FIT_W,
  parameter int STALL_LIMIT   = GA_STALL_LIMIT
) (
  input logic                 clk,
  input logic                 rst_n,
  ga_generation_ctrl_if.master bus
);
  localparam int GW = $clog2(GENERATIONS + 1);

  STATES         state, state_nxt;
  logic          go_q, go_nxt, start_run;
  logic [GW-1:0] gen_count;
  logic          adv, at_limit, rank_adv, stall_hit;

  // A done that coincides with go belongs to the previous stage and is dropped.
  assign adv      = bus.stage_done && !go_q;
  assign at_limit = (gen_count == GW'(GENERATIONS));
  assign rank_adv = (state == RANK_ROUTES) && adv && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      go_q  <= go_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    if (bus.abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE, DONE:  if (bus.start) begin
                       state_nxt = INITIALIZE;
                       start_run = 1'b1;
                     end
        INITIALIZE:  if (adv) state_nxt = RANK_ROUTES;
        RANK_ROUTES: if (adv) state_nxt = (at_limit || stall_hit) ? DONE : SELECTION;
        SELECTION:   if (adv) state_nxt = BREED;
        BREED:       if (adv) state_nxt = (MUTATION_RATE == 0) ? NEXT_GEN : MUTATE;
        MUTATE:      if (adv) state_nxt = NEXT_GEN;
        NEXT_GEN:    if (adv) state_nxt = RANK_ROUTES;
        default:     state_nxt = IDLE;
      endcase
    end
    go_nxt = (state_nxt != state) && is_engine(state_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                gen_count <= '0;
    else if (start_run)                                        gen_count <= '0;
    else if ((state == NEXT_GEN) && adv && !bus.abort && !at_limit) gen_count <= gen_count + 1'b1;
  end

  ga_best_tracker #(.FIT_W(FIT_W), .GW(GW), .STALL_LIMIT(STALL_LIMIT)) u_best (
    .clk(clk), .rst_n(rst_n), .clr(start_run), .upd(rank_adv),
    .fit_valid(bus.fit_valid), .fit_in(bus.fit_in), .gen_count(gen_count),
    .best_fit(bus.best_fit), .best_gen(bus.best_gen), .stall_hit(stall_hit)
  );

`ifdef GA_STAGNATION_STOP_EN
  ga_stop_e stop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   stop_q <= STOP_GENS;
    else if (start_run)                           stop_q <= STOP_GENS;
    else if (rank_adv && !at_limit && stall_hit)  stop_q <= STOP_STALL;
  end
  assign bus.stop_reason = stop_q;
`else
  assign bus.stop_reason = 1'b0;
`endif

  assign bus.stage      = state;
  assign bus.stage_go   = go_q;
  assign bus.gen_count  = gen_count;
  assign bus.busy       = is_engine(state);
  assign bus.done       = (state == DONE);
  assign bus.pop_size   = 16'(POP_SIZE);
  assign bus.elite_size = 16'(ELITE_SIZE);
  assign bus.mut_rate   = 16'(MUTATION_RATE);
endmodule
